emac_tx_framer: RTL
===================

Name: emac_tx_framer

Overview:
- Store-and-forward transmit framer sitting directly upstream of the GMII/GTX transmit stage.
- Accepts one Ethernet frame (DA..payload, no preamble/FCS) on a ready/valid byte stream into a single-frame buffer.
- Pads the frame to a minimum length, then streams it out using the tx_data/tx_data_valid/tx_ack handshake the transmit stage expects.
- Appends the 4-byte FCS on crc_data/crc_en.

Parameters:
- MAX_LEN, 1536: buffer size in bytes; longer frames are dropped.
- MIN_LEN, 60: minimum pre-FCS length; shorter frames are zero-padded. 0 disables padding.
- AW, 11: buffer address width; must satisfy 2^AW >= MAX_LEN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  frame byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks last byte of frame; qualified by in_valid.
- in_ready  out  1  framer accepts byte this cycle.
- tx_data  out  8  byte to transmit stage.
- tx_data_valid  out  1  frame bytes valid (including pad bytes).
- tx_ack  in  1  one-cycle pulse from transmit stage: byte 0 is being consumed.
- crc_data  out  8  FCS byte.
- crc_en  out  1  high for exactly 4 consecutive cycles carrying the FCS.
- drop_cnt  out  16  count of frames dropped as oversize; saturating.

Behaviour:
- Reset (async assert, sync deassert): state IDLE; in_ready=0; tx_data=0; tx_data_valid=0; crc_data=0; crc_en=0; drop_cnt=0; write pointer and length cleared. Reset mid-frame abandons the frame with no partial output.
- FSM states: IDLE, LOAD, DROP, PREF, REQ, DATA, PAD, FCS, GAP.
- IDLE: in_ready=1 next cycle; go to LOAD.
- LOAD: in_ready=1. Each in_valid byte is written to buffer[wr_ptr] and CRC-updated is deferred (CRC is computed on readout).
  - in_last with length<=MAX_LEN: latch len, in_ready=0, go to PREF.
  - Byte number MAX_LEN+1 without in_last: go to DROP.
- DROP: in_ready=1; discard bytes up to and including in_last; drop_cnt+1 (saturating at 0xFFFF); go to IDLE.
- PREF: one cycle of buffer read latency for byte 0; go to REQ.
- REQ: tx_data=byte0, tx_data_valid=1, held until tx_ack is sampled high.
  - tx_ack coincides with byte0 being consumed.
  - Byte1 is presented the cycle after tx_ack is sampled; bytes then follow strictly back-to-back, one per cycle, with no gaps.
  - tx_ack seen outside REQ is ignored.
- DATA: present bytes 1..len-1. If len<MIN_LEN go to PAD, else FCS.
- PAD: tx_data=0x00, tx_data_valid=1 for MIN_LEN-len cycles.
- FCS: the cycle after the last valid byte, tx_data_valid=0 and crc_en=1 for 4 cycles. crc_data carries ~CRC, least-significant byte first.
- CRC definition:
  - CRC-32 IEEE 802.3: reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated one byte per cycle over every byte presented with tx_data_valid=1, pad bytes included.
  - Byte-wide combinational update.
- GAP: one idle cycle with tx_data_valid=0 and crc_en=0; go to IDLE.
- crc_en and tx_data_valid are never high in the same cycle.
- Inter-frame gap is owned by the transmit stage. The next frame's REQ simply waits for the next tx_ack.
- Length-1 frame: PREF→REQ→(PAD or FCS). No DATA cycles; a single-byte frame is legal.
- Frame of exactly MAX_LEN bytes is accepted. MAX_LEN+1 is dropped.
- in_valid while in_ready=0 is ignored. Upstream holds the byte per ready/valid rules.

Decomposition:
- Shared package (emac_pkg) holds:
  - state encodings;
  - CRC32_INIT=32'hFFFFFFFF;
  - CRC32_POLY_REF=32'hEDB88320;
  - ETH_MIN_LEN=60;
  - function crc32_byte(crc, data).
- One sub-module: emac_tx_buf_ram, a simple dual-port RAM with synchronous write, 1-cycle registered read, 8 bits × 2^AW.

Test Plan:
- MIN_LEN=0, frame "123456789" (0x31..0x39), tx_ack pulsed 10 cycles after valid → tx_data 0x31 held until ack; then 0x32..0x39 back-to-back; crc_data 0x26,0x39,0xF4,0xCB with crc_en 4 cycles; drop_cnt=0.
- Default MIN_LEN, 14-byte frame → exactly 60 bytes valid (46 trailing 0x00 pads); FCS matches reference model over all 60 bytes; tx_data_valid and crc_en never overlap.
- Frame of 1537 bytes then a 64-byte frame → first produces no tx_data_valid and drop_cnt=1; second is transmitted intact with correct FCS.
- Two back-to-back 64-byte frames, tx_ack delayed 30 cycles for the second → in_ready low until first FCS+GAP done; second byte0 held stable for all 30 cycles; both FCS correct.
- Assert rst_n low mid-DATA of a 100-byte frame → all outputs 0 asynchronously; after release, a new 60-byte frame is transmitted correctly.
- 1536-byte frame → accepted; 1536 data bytes then 4 FCS bytes, no padding.

Source files
------------

// File: rtl/emac_pkg.sv
// rtl/emac_pkg.sv - shared types, constants and CRC helper for the EMAC transmit framer
package emac_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DROP,
        ST_PREF,
        ST_REQ,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_GAP
    } emac_state_t;

    localparam logic [31:0] CRC32_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY_REF = 32'hEDB8_8320;
    localparam int          ETH_MIN_LEN    = 60;

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REF) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/emac_tx_framer_if.sv
// rtl/emac_tx_framer_if.sv - ingress stream, transmit-stage handshake and FCS bundle
interface emac_tx_framer_if;

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_ack;
    logic [7:0]  crc_data;
    logic        crc_en;
    logic [15:0] drop_cnt;

    modport master (
        input  in_data, in_valid, in_last, tx_ack,
        output in_ready, tx_data, tx_data_valid, crc_data, crc_en, drop_cnt
    );

    modport slave (
        output in_data, in_valid, in_last, tx_ack,
        input  in_ready, tx_data, tx_data_valid, crc_data, crc_en, drop_cnt
    );

endinterface

// File: rtl/emac_tx_buf_ram.sv
// rtl/emac_tx_buf_ram.sv - single-frame byte buffer, synchronous write and registered read
module emac_tx_buf_ram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [2**AW];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/emac_tx_framer.sv
// rtl/emac_tx_framer.sv - store-and-forward framer: buffer, pad, stream out, append FCS
module emac_tx_framer
    import emac_pkg::*;
#(
    parameter int MAX_LEN = 1536,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int AW      = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    emac_tx_framer_if.master  bus
);

    localparam int            LW    = AW + 1;
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] MIN_L = LW'(MIN_LEN);

    emac_state_t   state_q, state_d;
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [31:0]   crc_q, crc_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [7:0]    ram_rdata;
    logic          need_pad;
    logic          tx_valid;
    logic          byte_sent;
    logic [7:0]    tx_byte;
    logic [31:0]   fcs_word;

    emac_tx_buf_ram #(.AW(AW)) u_buf (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (bus.in_data),
        .rd_en_i   (ram_re),
        .rd_addr_i (ram_raddr),
        .rd_data_o (ram_rdata)
    );

    // Bytes past the buffer end are never written; the frame is dropped anyway.
    assign ram_we    = (state_q == ST_LOAD) && bus.in_valid && (wr_ptr_q < MAX_L);
    assign need_pad  = (len_q < MIN_L);
    assign tx_valid  = (state_q == ST_REQ) || (state_q == ST_DATA) || (state_q == ST_PAD);
    assign tx_byte   = (state_q == ST_PAD) ? 8'h00 : ram_rdata;
    assign byte_sent = ((state_q == ST_REQ) && bus.tx_ack) || (state_q == ST_DATA) || (state_q == ST_PAD);
    assign fcs_word  = ~crc_q;

    assign bus.in_ready      = (state_q == ST_LOAD) || (state_q == ST_DROP);
    assign bus.tx_data_valid = tx_valid;
    assign bus.tx_data       = tx_valid ? tx_byte : 8'h00;
    assign bus.crc_en        = (state_q == ST_FCS);
    assign bus.crc_data      = (state_q == ST_FCS) ? fcs_word[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign bus.drop_cnt      = drop_cnt_q;

    always_comb begin
        crc_d = crc_q;
        if (state_q == ST_IDLE) begin
            crc_d = CRC32_INIT;
        end else if (byte_sent) begin
            crc_d = crc32_byte(crc_q, tx_byte);
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        drop_cnt_d = drop_cnt_q;
        ram_re     = 1'b0;
        ram_raddr  = '0;
        unique case (state_q)
            ST_IDLE: begin
                wr_ptr_d = '0;
                cnt_d    = '0;
                state_d  = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    wr_ptr_d = wr_ptr_q + LW'(1);
                    // wr_ptr_q == MAX_L means this is byte MAX_LEN+1.
                    if (wr_ptr_q == MAX_L) begin
                        if (bus.in_last) begin
                            drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                            state_d    = ST_IDLE;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else if (bus.in_last) begin
                        len_d   = wr_ptr_q + LW'(1);
                        state_d = ST_PREF;
                    end
                end
            end
            ST_DROP: begin
                if (bus.in_valid && bus.in_last) begin
                    drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            ST_PREF: begin
                ram_re  = 1'b1;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.tx_ack) begin
                    ram_re    = 1'b1;
                    ram_raddr = AW'(1);
                    cnt_d     = LW'(1);
                    if (len_q != LW'(1)) begin
                        state_d = ST_DATA;
                    end else if (need_pad) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FCS;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                // Prefetch the next byte every cycle so the stream has no gaps.
                ram_re    = 1'b1;
                ram_raddr = cnt_q[AW-1:0] + AW'(1);
                cnt_d     = cnt_q + LW'(1);
                if (cnt_q == len_q - LW'(1)) begin
                    if (need_pad) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_FCS;
                        cnt_d   = '0;
                    end
                end
            end
            ST_PAD: begin
                cnt_d = cnt_q + LW'(1);
                if (cnt_q == MIN_L - LW'(1)) begin
                    state_d = ST_FCS;
                    cnt_d   = '0;
                end
            end
            ST_FCS: begin
                cnt_d = cnt_q + LW'(1);
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            crc_q      <= CRC32_INIT;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            crc_q      <= crc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
